// File: rtl/uart_cmd_parser.sv
// UART command parser: takes "<P|I|D><digits><CR|LF>" lines and loads
// the kp/ki/kd gain registers; bad lines raise a one-cycle cmd_err.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   rx_data, rx_valid     received byte and its one-cycle strobe
//   tx_busy               transmitter cannot accept a byte
//   tx_data, tx_start     response byte and its one-cycle start strobe
//   kp, ki, kd            gain registers (GAIN_W bits each)
//   cmd_valid, cmd_err    command applied / command rejected pulses
//
// Build option: define CMD_ACK_EN to send 'K' / 'E' responses.
// Without it, tx_start and tx_data are tied to zero.

module uart_cmd_parser #(
  parameter int GAIN_W     = 16,
  parameter int MAX_DIGITS = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic [GAIN_W-1:0] kp,
  output logic [GAIN_W-1:0] ki,
  output logic [GAIN_W-1:0] kd,
  output logic              cmd_valid,
  output logic              cmd_err
);

  localparam int ACC_W = GAIN_W + 4;
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  localparam logic [ACC_W-1:0] ACC_MAX =
    {{4{1'b0}}, {GAIN_W{1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

  typedef enum logic [1:0] {
    IDLE,
    DIGITS,
    DISCARD
  } state_t;

  typedef enum logic [1:0] {
    SEL_P,
    SEL_I,
    SEL_D
  } sel_t;

  state_t            state_q, state_d;
  sel_t              sel_q, sel_d;
  logic [GAIN_W-1:0] acc_q, acc_d;
  logic              sat_q, sat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GAIN_W-1:0] kp_q, kp_d;
  logic [GAIN_W-1:0] ki_q, ki_d;
  logic [GAIN_W-1:0] kd_q, kd_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_err_q, cmd_err_d;

  // Byte classification
  logic       is_term;
  logic       is_digit;
  logic       is_sel;
  logic [3:0] digit;
  sel_t       sel_of;

  always_comb begin
    is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_sel   = (rx_data == 8'h50) || (rx_data == 8'h49)
            || (rx_data == 8'h44);
    digit    = rx_data[3:0];
    sel_of   = SEL_D;
    if (rx_data == 8'h50) begin
      sel_of = SEL_P;
    end else if (rx_data == 8'h49) begin
      sel_of = SEL_I;
    end
  end

  // acc*10 + digit in GAIN_W+4 bits; acc never exceeds
  // 2^GAIN_W-1, so the product cannot wrap in this width.
  logic [ACC_W-1:0]  acc_ext;
  logic [ACC_W-1:0]  acc_mul;
  logic              sat_hit;
  logic [GAIN_W-1:0] acc_next;

  always_comb begin
    acc_ext  = {4'b0000, acc_q};
    acc_mul  = (acc_ext << 3) + (acc_ext << 1)
             + {{(ACC_W-4){1'b0}}, digit};
    sat_hit  = sat_q || (acc_mul > ACC_MAX);
    acc_next = sat_hit ? ACC_MAX[GAIN_W-1:0]
                       : acc_mul[GAIN_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    cnt_d       = cnt_q;
    kp_d        = kp_q;
    ki_d        = ki_q;
    kd_d        = kd_q;
    cmd_valid_d = 1'b0;
    cmd_err_d   = 1'b0;

    if (rx_valid) begin
      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            is_sel: begin
              sel_d   = sel_of;
              acc_d   = '0;
              sat_d   = 1'b0;
              cnt_d   = '0;
              state_d = DIGITS;
            end
            is_term: begin
              // Stray CR/LF (e.g. LF of CRLF)
              state_d = IDLE;
            end
            default: begin
              cmd_err_d = 1'b1;
              state_d   = DISCARD;
            end
          endcase
        end

        DIGITS: begin
          unique case (1'b1)
            is_digit: begin
              if (cnt_q == CNT_MAX) begin
                cmd_err_d = 1'b1;
                state_d   = DISCARD;
              end else begin
                acc_d = acc_next;
                sat_d = sat_hit;
                cnt_d = cnt_q + 1'b1;
              end
            end
            is_term: begin
              if (cnt_q == '0) begin
                cmd_err_d = 1'b1;
              end else begin
                cmd_valid_d = 1'b1;
                unique case (sel_q)
                  SEL_P:   kp_d = acc_q;
                  SEL_I:   ki_d = acc_q;
                  default: kd_d = acc_q;
                endcase
              end
              state_d = IDLE;
            end
            default: begin
              cmd_err_d = 1'b1;
              state_d   = DISCARD;
            end
          endcase
        end

        DISCARD: begin
          if (is_term) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= SEL_P;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      cnt_q       <= '0;
      kp_q        <= '0;
      ki_q        <= '0;
      kd_q        <= '0;
      cmd_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      cnt_q       <= cnt_d;
      kp_q        <= kp_d;
      ki_q        <= ki_d;
      kd_q        <= kd_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign kp        = kp_q;
  assign ki        = ki_q;
  assign kd        = kd_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_err   = cmd_err_q;

`ifdef CMD_ACK_EN
  // One-entry response slot; the newest response wins.
  logic       ack_pend_q, ack_pend_d;
  logic [7:0] ack_byte_q, ack_byte_d;

  assign tx_start = ack_pend_q & ~tx_busy;
  assign tx_data  = ack_byte_q;

  always_comb begin
    ack_pend_d = ack_pend_q;
    ack_byte_d = ack_byte_q;
    if (cmd_valid_d) begin
      ack_pend_d = 1'b1;
      ack_byte_d = 8'h4B;
    end else if (cmd_err_d) begin
      ack_pend_d = 1'b1;
      ack_byte_d = 8'h45;
    end else if (tx_start) begin
      ack_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_pend_q <= 1'b0;
      ack_byte_q <= 8'h00;
    end else begin
      ack_pend_q <= ack_pend_d;
      ack_byte_q <= ack_byte_d;
    end
  end
`else
  logic unused_tx_busy;

  assign unused_tx_busy = tx_busy;
  assign tx_start       = 1'b0;
  assign tx_data        = 8'h00;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Testbench for uart_cmd_parser: directed lines plus random command
// streams checked against a line-buffer model of the command grammar.

module tb_uart_cmd_parser;

  localparam int GW   = 16;
  localparam int MAXD = 5;
  localparam longint GMAX = (longint'(1) << GW) - 1;

  logic          clk;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          tx_busy;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic [GW-1:0] kp;
  logic [GW-1:0] ki;
  logic [GW-1:0] kd;
  logic          cmd_valid;
  logic          cmd_err;

  uart_cmd_parser #(
    .GAIN_W    (GW),
    .MAX_DIGITS(MAXD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .kp       (kp),
    .ki       (ki),
    .kd       (kd),
    .cmd_valid(cmd_valid),
    .cmd_err  (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] line_q[$];
  bit         line_bad;
  longint     m_kp, m_ki, m_kd;
  bit         m_pend;
  logic [7:0] m_byte;
  bit         m_last_start;
  int         n_valid, n_err, n_start;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit line_ok();
    if (line_q.size() == 0) return 1'b1;
    if (!(line_q[0] inside {8'h50, 8'h49, 8'h44})) return 1'b0;
    if (line_q.size() - 1 > MAXD) return 1'b0;
    for (int i = 1; i < line_q.size(); i++)
      if (!(line_q[i] inside {[8'h30:8'h39]})) return 1'b0;
    return 1'b1;
  endfunction

  // resp: 0 none, 1 command applied, 2 command rejected
  task automatic mdl(input logic [7:0] b, output int resp);
    longint v;
    resp = 0;
    if (b == 8'h0D || b == 8'h0A) begin
      if (line_q.size() != 0 && !line_bad) begin
        if (line_q.size() == 1) begin
          resp = 2;
        end else begin
          v = 0;
          for (int i = 1; i < line_q.size(); i++)
            v = v * 10 + longint'(line_q[i] - 8'h30);
          if (v > GMAX) v = GMAX;
          if (line_q[0] == 8'h50) m_kp = v;
          else if (line_q[0] == 8'h49) m_ki = v;
          else m_kd = v;
          resp = 1;
        end
      end
      line_q.delete();
      line_bad = 1'b0;
    end else begin
      line_q.push_back(b);
      if (!line_bad && !line_ok()) begin
        line_bad = 1'b1;
        resp = 2;
      end
    end
  endtask

  task automatic mdl_reset();
    line_q.delete();
    line_bad     = 1'b0;
    m_kp         = 0;
    m_ki         = 0;
    m_kd         = 0;
    m_pend       = 1'b0;
    m_byte       = 8'h00;
    m_last_start = 1'b0;
  endtask

  // Called once per cycle at the falling edge
  task automatic observe(input int resp);
    chk("cmd_valid", cmd_valid, (resp == 1));
    chk("cmd_err", cmd_err, (resp == 2));
    chk("excl", cmd_valid & cmd_err, 0);
    chk("kp", kp, m_kp[31:0]);
    chk("ki", ki, m_ki[31:0]);
    chk("kd", kd, m_kd[31:0]);
    if (cmd_valid === 1'b1) n_valid++;
    if (cmd_err === 1'b1) n_err++;
    if (tx_start === 1'b1) n_start++;
`ifdef CMD_ACK_EN
    if (resp != 0) begin
      m_pend = 1'b1;
      m_byte = (resp == 1) ? 8'h4B : 8'h45;
    end else if (m_last_start) begin
      m_pend = 1'b0;
    end
    chk("tx_start", tx_start, m_pend & !tx_busy);
    if (m_pend) chk("tx_data", tx_data, m_byte);
    m_last_start = m_pend & !tx_busy;
`else
    chk("tx_start", tx_start, 0);
    chk("tx_data", tx_data, 0);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      observe(0);
    end
  endtask

  task automatic set_busy(input logic b);
    tx_busy      = b;
    m_last_start = m_pend & !tx_busy;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int r;
    mdl(b, r);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom_range(0, 255));
    observe(r);
    idle(gap);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], 0);
  endtask

  initial begin
    logic [7:0] cmd[$];
    int         r;
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_busy  = 1'b0;
    mdl_reset();
    n_valid  = 0;
    n_err    = 0;
    n_start  = 0;

    // Reset state
    repeat (2) begin
      @(negedge clk);
      observe(0);
    end
    chk("rst_tx_data", tx_data, 0);
    reset = 1'b0;
    idle(2);

    // "P123\r"
    send_str("P123\r");
    chk("p123_kp", kp, 123);
    chk("p123_ki", ki, 0);
    idle(3);

    // Saturation
    send_str("D99999\n");
    chk("sat_kd", kd, 65535);
    idle(2);

    // Too many digits
    n_err = 0;
    send_str("I123456\n");
    chk("long_ki", ki, 0);
    chk("long_err", n_err, 1);
    idle(2);

    // Bad selector, then CRLF-terminated command
    n_err   = 0;
    n_valid = 0;
    send_str("X5\r\nP7\r\n");
    idle(2);
    chk("x5_err", n_err, 1);
    chk("x5_valid", n_valid, 1);
    chk("x5_kp", kp, 7);

    // Empty command
    n_err = 0;
    send_str("I\r");
    chk("empty_err", n_err, 1);
    idle(2);

    // Responses while transmitter is busy
    set_busy(1'b1);
    send_str("P1\r");
    send_str("Q\r");
    idle(95);
    n_start = 0;
    set_busy(1'b0);
    idle(5);
`ifdef CMD_ACK_EN
    chk("busy_starts", n_start, 1);
`else
    chk("busy_starts", n_start, 0);
`endif
    chk("busy_kp", kp, 1);

    // Random command streams
    for (int c = 0; c < 60; c++) begin
      cmd.delete();
      r = $urandom_range(0, 9);
      if (r <= 6) begin
        r = $urandom_range(0, 2);
        cmd.push_back(r == 0 ? 8'h50 : (r == 1 ? 8'h49 : 8'h44));
      end else if (r == 7) begin
        cmd.push_back(8'h70);
      end else if (r == 8) begin
        cmd.push_back(8'($urandom_range(0, 255)));
      end
      r = $urandom_range(0, 7);
      for (int d = 0; d < r; d++) begin
        if ($urandom_range(0, 15) == 0)
          cmd.push_back(8'($urandom_range(32, 126)));
        else
          cmd.push_back(8'($urandom_range(8'h30, 8'h39)));
      end
      r = $urandom_range(0, 2);
      if (r == 0) cmd.push_back(8'h0D);
      else if (r == 1) cmd.push_back(8'h0A);
      else begin
        cmd.push_back(8'h0D);
        cmd.push_back(8'h0A);
      end
      if ($urandom_range(0, 3) == 0)
        set_busy(1'($urandom_range(0, 1)));
      foreach (cmd[k])
        send_byte(cmd[k], $urandom_range(0, 2));
    end
    set_busy(1'b0);
    idle(4);

    // Reset in the middle of a command
    send_str("K4");
    @(negedge clk);
    reset = 1'b1;
    mdl_reset();
    #1;
    chk("rst_mid_kp", kp, 0);
    chk("rst_mid_tx", tx_start, 0);
    idle(2);
    reset   = 1'b0;
    n_valid = 0;
    n_err   = 0;
    send_str("\r");
    idle(3);
    chk("rst_kp", kp, 0);
    chk("rst_ki", ki, 0);
    chk("rst_kd", kd, 0);
    chk("rst_pulses", n_valid + n_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
